// File: rtl/eac_frame_accumulator.sv
// Streaming mod-255 end-around-carry frame checksum; 1 cycle from last accepted word to out_valid.
// Backpressure: in_ready is high only in ACCUM; out_data holds while out_valid & !out_ready.
// Optional NORM_ZERO_EN maps the 0xFF zero encoding to 0x00 on out_data only.
module eac_frame_accumulator #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    generate
        if (DATA_W != 8) begin : g_width_check
            $error("eac_frame_accumulator: DATA_W must be 8 to match the node adder");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                busy_q, busy_d;

    // Node adder: operand a is the accumulator, b the incoming word; carry wraps back in.
    logic [DATA_W:0]     node_sum;
    logic [DATA_W-1:0]   acc_next;
    logic [DATA_W-1:0]   sum_out;

    always_comb begin
        node_sum = {1'b0, acc_q} + {1'b0, in_data};
        acc_next = node_sum[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, node_sum[DATA_W]};
`ifdef NORM_ZERO_EN
        sum_out  = (acc_next == {DATA_W{1'b1}}) ? {DATA_W{1'b0}} : acc_next;
`else
        sum_out  = acc_next;
`endif
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ACCUM;
                    end else begin
                        out_data_d = '0;
                        state_d    = DONE;
                    end
                end
            end
            ACCUM: begin
                if (in_valid && in_ready_q) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        out_data_d = sum_out;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they come straight off flops.
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_eac_frame_accumulator.sv
// Scoreboard bench for eac_frame_accumulator: directed frames then randomized frames
// checked against an arithmetic mod-255 reference model.
module tb_eac_frame_accumulator;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic [7:0] len, in_data;
    logic       in_ready, out_valid, busy;
    logic [7:0] out_data;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    bit hold_low = 1'b0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    eac_frame_accumulator #(.CNT_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT response within cycle budget", name);
    endtask

    // Mod-255 sum of the frame; 0x00 only when every word was zero, else 0xFF stands for zero.
    function automatic logic [7:0] model(input int unsigned total);
        int unsigned r;
        logic [7:0] v;
        if (total == 0) v = 8'h00;
        else begin
            r = total % 255;
            v = (r == 0) ? 8'hFF : 8'(r);
        end
`ifdef NORM_ZERO_EN
        if (v == 8'hFF) v = 8'h00;
`endif
        return v;
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_low ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold stability.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) prev_stall = 1'b0;
            else begin
                if (prev_stall) chk("hold_stable", out_data, prev_data);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got 0x%0h, required no output", out_data);
                    end else chk("checksum", out_data, exp_q.pop_front());
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        fail_now(name);
    endtask

    task automatic start_frame(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = 8'($urandom);
    endtask

    task automatic send_word(input logic [7:0] d, input int gap);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        fail_now("in_ready_wait");
        in_valid = 1'b0;
    endtask

    task automatic run_list(input logic [7:0] w[$], input int gapmax);
        int unsigned total;
        total = 0;
        foreach (w[i]) total += w[i];
        exp_q.push_back(model(total));
        start_frame(8'(w.size()));
        if (w.size() == 0) begin
            @(negedge clk);
            chk("len0_out_valid", out_valid, 1);
            chk("len0_in_ready", in_ready, 0);
        end else begin
            foreach (w[i]) send_word(w[i], $urandom_range(0, gapmax));
            in_valid = 1'b0;
            @(negedge clk);
            chk("latency_out_valid", out_valid, 1);
        end
        wait_idle("frame_idle");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w[$];
        logic [7:0] exp;
        rst = 1'b1; start = 1'b0; len = 8'h00; in_valid = 1'b0; in_data = 8'h00;

        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        w = '{8'h10, 8'h20, 8'h30};
        run_list(w, 0);
        w = '{8'hFF, 8'h01};
        run_list(w, 0);
        w = '{8'hFE, 8'h01};
        run_list(w, 0);
        w = '{8'h80, 8'h80};
        run_list(w, 0);
        w = '{8'hFF, 8'hFF};
        run_list(w, 1);

        // Stalled output: data held, start pulses ignored, including the exit cycle.
        hold_low = 1'b1;
        exp = model(32'h11 + 32'h22 + 32'h33 + 32'h44);
        exp_q.push_back(exp);
        start_frame(8'd4);
        send_word(8'h11, 0);
        send_word(8'h22, 1);
        send_word(8'h33, 1);
        send_word(8'h44, 1);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_busy", busy, 1);
            chk("stall_out_data", out_data, exp);
            start = (k == 2);
            len   = 8'd5;
        end
        start = 1'b1;
        hold_low = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("post_exit_busy", busy, 0);
        chk("post_exit_in_ready", in_ready, 0);
        chk("post_exit_out_valid", out_valid, 0);
        @(negedge clk);
        chk("post_exit_busy2", busy, 0);

        // Zero-length frame: checksum 0x00, in_ready never rises.
        exp_q.push_back(8'h00);
        start_frame(8'd0);
        @(negedge clk);
        chk("len0_out_valid", out_valid, 1);
        chk("len0_out_data", out_data, 8'h00);
        for (int i = 0; i < 4 && busy; i++) begin
            chk("len0_no_in_ready", in_ready, 0);
            @(negedge clk);
        end
        wait_idle("len0_idle");

        // Reset mid-frame abandons the frame with no output.
        start_frame(8'd4);
        send_word(8'h37, 0);
        send_word(8'h42, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 8'h00);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        w = '{8'h5A};
        run_list(w, 0);

        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int l;
            w = {};
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            for (int i = 0; i < l; i++) begin
                case ($urandom_range(0, 3))
                    0: w.push_back(8'hFF);
                    1: w.push_back(8'h00);
                    default: w.push_back(8'($urandom));
                endcase
            end
            run_list(w, $urandom_range(0, 2));
        end
        rand_rdy = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
